lc3_bus_demux_3_16: RTL
=======================

Name: lc3_bus_demux_3_16

Overview:
- Destination-side counterpart of the 16-bit 3:1 source mux on the LC-3 datapath bus.
- Takes one 16-bit bus word plus a 2-bit destination select and latches it into one of three holding registers.
- Each register has its own valid flag and consumer acknowledge.
- Sits between the bus and the downstream latches (MAR/MDR/IR-side consumers). Adds a valid/ready handshake, backpressure and illegal-select accounting.

Parameters:
- WIDTH, 16, data width of the bus word and each holding register
- ERR_CNT_W, 8, width of the saturating illegal-select counter

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in_data  input  WIDTH  bus word
- in_sel  input  2  destination: 00 → dest 0, 01 → dest 1, 10 → dest 2, 11 → illegal
- in_valid  input  1  producer presents a word
- in_ready  output  1  block can accept the word addressed by in_sel
- out_data_0  output  WIDTH  holding register 0
- out_data_1  output  WIDTH  holding register 1
- out_data_2  output  WIDTH  holding register 2
- out_valid  output  3  bit k set means out_data_k holds an unconsumed word
- out_ack  input  3  bit k: consumer k takes its word this cycle
- sel_err  output  1  one-cycle pulse after an illegal-select transfer
- err_count  output  ERR_CNT_W  saturating count of illegal-select transfers

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-transfer):
  - out_data_0/1/2 = 0, out_valid = 3'b000, sel_err = 0, err_count = 0.
  - Any transfer in flight is discarded.
- in_ready is combinational from in_sel, out_valid and out_ack only. It never depends on in_valid.
  - in_sel = k (0..2): in_ready = ~out_valid[k] | out_ack[k].
  - in_sel = 11: in_ready = 1.
- Transfer: occurs on a rising edge where in_valid & in_ready.
- Legal transfer to k:
  - out_data_k <= in_data; out_valid[k] <= 1.
  - Latency 1 cycle: the word is visible on the edge after acceptance.
  - Other registers are unchanged.
- Illegal transfer (in_sel = 11):
  - Data dropped; no out_valid bit changes.
  - sel_err = 1 for exactly the next cycle.
  - err_count increments, saturating at all-ones.
- Acknowledge:
  - out_valid[k] & out_ack[k] clears out_valid[k] on the edge; out_data_k holds its last value.
  - out_ack[k] while out_valid[k] = 0 is ignored.
- Simultaneous ack and transfer to the same k: the load wins. out_valid[k] stays 1 and out_data_k takes the new word. This gives full throughput of one word per cycle per destination.
- Acks to other destinations in the same cycle as a transfer are processed independently.
- Backpressure: while out_valid[k] = 1 and out_ack[k] = 0, a word addressed to k stalls. Producer must hold in_data/in_sel/in_valid stable until accepted.
- Multiple out_ack bits may be asserted together; each is handled independently.
- sel_err is otherwise 0. Back-to-back illegal transfers hold sel_err at 1 continuously.

Optional Feature:
- Macro: LC3_NZP_GEN_EN.
- Defined:
  - Adds outputs out_nzp_0, out_nzp_1, out_nzp_2 (3 bits each, {N,Z,P}), registered alongside out_data_k on each legal transfer to k.
  - N = in_data[WIDTH-1]; Z = (in_data == 0); P = ~N & ~Z.
  - Reset value 3'b010 (Z), consistent with the zero data reset.
  - Acknowledge does not change out_nzp_k.
- Not defined: these ports and their registers do not exist; all other behaviour is identical.

Test Plan:
- Reset check: assert reset mid-run with out_valid = 3'b101 → immediately out_valid = 0, all out_data = 0, err_count = 0, sel_err = 0.
- Basic route: in_data = 16'h3A5C, in_sel = 01, in_valid = 1, out_ack = 0 → next cycle out_data_1 = 16'h3A5C, out_valid = 3'b010, out_data_0 and out_data_2 unchanged.
- Backpressure: dest 0 full, out_ack = 0; offer 16'h1111 to sel 00 → in_ready = 0 for 3 cycles. Assert out_ack[0] → transfer completes on that edge; out_data_0 = 16'h1111, out_valid[0] stays 1.
- Full throughput: stream 16'h0001..16'h0008 to sel 10 with out_ack[2] tied to 1 → one word accepted per cycle; out_data_2 steps through each value; out_valid[2] = 1 throughout.
- Illegal select: 300 consecutive transfers with in_sel = 11 → sel_err high during the cycles following them, no out_valid change, err_count saturates at 8'hFF.
- With LC3_NZP_GEN_EN: load 16'h8000, 16'h0000 and 16'h0007 to dests 0, 1, 2 → out_nzp_0 = 100, out_nzp_1 = 010, out_nzp_2 = 001.

Source files
------------

// File: rtl/lc3_bus_demux_3_16.sv
// LC-3 bus destination demux: routes one bus word into one of three holding
// registers with valid/ack handshake. Optional NZP flags under LC3_NZP_GEN_EN.
module lc3_bus_demux_3_16 #(
  parameter int WIDTH     = 16,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     in_data,
  input  logic [1:0]           in_sel,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [WIDTH-1:0]     out_data_0,
  output logic [WIDTH-1:0]     out_data_1,
  output logic [WIDTH-1:0]     out_data_2,
  output logic [2:0]           out_valid,
  input  logic [2:0]           out_ack,
`ifdef LC3_NZP_GEN_EN
  output logic [2:0]           out_nzp_0,
  output logic [2:0]           out_nzp_1,
  output logic [2:0]           out_nzp_2,
`endif
  output logic                 sel_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam logic [1:0] SEL_ILLEGAL = 2'b11;

  logic [WIDTH-1:0] data_q [3];
  logic [2:0]       valid_q;
  logic [2:0]       load;
  logic             xfer;
  logic             illegal_xfer;

  assign out_data_0 = data_q[0];
  assign out_data_1 = data_q[1];
  assign out_data_2 = data_q[2];
  assign out_valid  = valid_q;

  // Illegal selects always drain so a bad producer can never wedge the bus.
  always_comb begin
    in_ready = 1'b1;
    if (in_sel != SEL_ILLEGAL)
      in_ready = ~valid_q[in_sel] | out_ack[in_sel];
  end

  assign xfer         = in_valid & in_ready;
  assign illegal_xfer = xfer & (in_sel == SEL_ILLEGAL);

  always_comb begin
    load = '0;
    for (int unsigned k = 0; k < 3; k++)
      load[k] = xfer & (in_sel == 2'(k));
  end

  // Load takes priority over ack so a destination can take one word per cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      for (int unsigned k = 0; k < 3; k++)
        data_q[k] <= '0;
    end else begin
      for (int unsigned k = 0; k < 3; k++) begin
        if (load[k]) begin
          data_q[k]  <= in_data;
          valid_q[k] <= 1'b1;
        end else if (out_ack[k]) begin
          valid_q[k] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_err   <= 1'b0;
      err_count <= '0;
    end else begin
      sel_err <= illegal_xfer;
      if (illegal_xfer && (err_count != '1))
        err_count <= err_count + 1'b1;
    end
  end

`ifdef LC3_NZP_GEN_EN
  logic [2:0] nzp_q [3];
  logic [2:0] nzp_in;
  logic       nzp_n;
  logic       nzp_z;

  assign nzp_n  = in_data[WIDTH-1];
  assign nzp_z  = (in_data == '0);
  assign nzp_in = {nzp_n, nzp_z, ~nzp_n & ~nzp_z};

  assign out_nzp_0 = nzp_q[0];
  assign out_nzp_1 = nzp_q[1];
  assign out_nzp_2 = nzp_q[2];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned k = 0; k < 3; k++)
        nzp_q[k] <= 3'b010;
    end else begin
      for (int unsigned k = 0; k < 3; k++)
        if (load[k])
          nzp_q[k] <= nzp_in;
    end
  end
`endif

endmodule
